// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, ending in a registered one-cycle write-back strobe.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_we
);
  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned RD_W  = 5;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t state_q, state_d;

  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] mb_q, mb_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            wb_we_q, wb_we_d;

  // Operand decode at the accept edge
  logic            is_rem, a_sgn, b_sgn, a_neg, b_neg;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  assign is_rem      = funct3[2] & funct3[1];
  assign a_sgn       = (funct3 == 3'b001) | (funct3 == 3'b010) |
                       (funct3 == 3'b100) | (funct3 == 3'b110);
  assign b_sgn       = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign a_neg       = a_sgn & a[XLEN-1];
  assign b_neg       = b_sgn & b[XLEN-1];
  assign a_mag       = a_neg ? -a : a;
  assign b_mag       = b_neg ? -b : b;
  assign div_zero    = funct3[2] & (b == '0);
  assign div_ovf     = funct3[2] & ~funct3[0] & (a == INT_MIN) & (b == '1);
  assign special     = div_zero | div_ovf;
  assign special_res = div_zero ? (is_rem ? a : '1) : (is_rem ? '0 : INT_MIN);

  // One iteration step: hi/lo hold product halves or remainder/quotient
  logic [XLEN:0] mul_sum, div_shift, div_trial;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, mb_q};

  // Sign correction and result selection
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   div_sel, div_fix, fix_res;

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign div_sel  = op_q[1] ? hi_q : lo_q;
  assign div_fix  = neg_q ? -div_sel : div_sel;
  assign fix_res  = op_q[2] ? div_fix :
                    (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = start ? (special ? DONE : RUN) : IDLE;
      RUN:        if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
      FIX:        state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    neg_d    = neg_q;
    mb_d     = mb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rd_d     = rd_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_d  = funct3;
          neg_d = is_rem ? a_neg : (a_neg ^ b_neg);
          mb_d  = b_mag;
          hi_d  = '0;
          lo_d  = a_mag;
          cnt_d = '0;
          rd_d  = rd_in;
          if (special) result_d = special_res;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q[2]) begin
          // Restoring divide: keep the trial remainder only when it did not go negative
          if (!div_trial[XLEN]) begin
            hi_d = div_trial[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
      end
      FIX:     result_d = fix_res;
      default: ;
    endcase
    busy_d  = (state_d == RUN) | (state_d == FIX);
    done_d  = (state_d == DONE);
    wb_we_d = done_d & (rd_d != '0);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      mb_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wb_we_q  <= 1'b0;
    end else begin
      op_q     <= op_d;
      neg_q    <= neg_d;
      mb_q     <= mb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wb_we_q  <= wb_we_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_q;
  assign wb_we  = wb_we_q;

endmodule
